// File: rtl/smc_pkg.sv
// Shared constants and state encoding for the sequential MOSFET calculator front-end.
package smc_pkg;
    localparam int SMC_IW   = 3;
    localparam int RES_W    = 7;
    // 12*114 does not fit in 10 bits, so the weighted sum keeps an extra bit.
    localparam int SUM_W    = 11;
    localparam int OUT_W    = 8;
    localparam int WT_A     = 3;
    localparam int WT_B     = 4;
    localparam int WT_C     = 5;
    localparam int DIV_MEAN = 3;
    localparam int DIV_WT   = 12;

    typedef enum logic [2:0] {IDLE, LOAD, CALC, AVG, OUT} state_t;
endpackage

// File: rtl/smc_mos_unit.sv
// Combinational Id/gm evaluator for one transistor; the single shared calculator.
module smc_mos_unit import smc_pkg::*; #(
    parameter int IW = SMC_IW
) (
    input  logic [IW-1:0]    w,
    input  logic [IW-1:0]    v_gs,
    input  logic [IW-1:0]    v_ds,
    input  logic             mode0,
    output logic [RES_W-1:0] res
);
    localparam int PW = 3*IW + 1;

    logic [IW-1:0] vov;
    logic          triode;
    logic [PW-1:0] prod;

    assign vov    = v_gs - IW'(1);
    assign triode = vov > v_ds;

    always_comb begin
        if (mode0)
            prod = triode ? PW'(w) * PW'(v_ds) * ((PW'(vov) << 1) - PW'(v_ds))
                          : PW'(w) * PW'(vov) * PW'(vov);
        else
            prod = triode ? (PW'(w) * PW'(v_ds)) << 1
                          : (PW'(w) * PW'(vov)) << 1;
    end

    assign res = RES_W'(prod / PW'(3));
endmodule

// File: rtl/smc_seq_ctrl.sv
// Frame loader, one-per-cycle evaluation with running descending sort, and 3-entry averager.
// Optional protocol checker (err output) enabled by defining SMC_PROTO_CHK_EN.
module smc_seq_ctrl import smc_pkg::*; #(
    parameter int N_MOS = 6,
    parameter int IW    = SMC_IW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [IW-1:0]    W,
    input  logic [IW-1:0]    V_GS,
    input  logic [IW-1:0]    V_DS,
`ifdef SMC_PROTO_CHK_EN
    output logic             err,
`endif
    output logic             out_valid,
    output logic [OUT_W-1:0] out_n
);
    localparam int CW = $clog2(N_MOS + 1);

    state_t                         state;
    logic [CW-1:0]                  beat_cnt, calc_cnt;
    logic [1:0]                     mode_q;
    logic [N_MOS-1:0][IW-1:0]       w_q, vgs_q, vds_q;
    logic [N_MOS-1:0][RES_W-1:0]    list_q, list_ins;
    logic [N_MOS-1:0]               gt;
    logic [IW-1:0]                  op_w, op_vgs, op_vds;
    logic [RES_W-1:0]               res, a, b, c;
    logic [SUM_W-1:0]               sum;

    always_comb begin
        op_w   = '0;
        op_vgs = '0;
        op_vds = '0;
        for (int i = 0; i < N_MOS; i++) begin
            if (calc_cnt == CW'(i)) begin
                op_w   = w_q[i];
                op_vgs = vgs_q[i];
                op_vds = vds_q[i];
            end
        end
    end

    smc_mos_unit #(.IW(IW)) u_mos (
        .w     (op_w),
        .v_gs  (op_vgs),
        .v_ds  (op_vds),
        .mode0 (mode_q[0]),
        .res   (res)
    );

    // Strict compare: equal values stay ahead of the newcomer, so ties keep the earlier entry first.
    for (genvar g = 0; g < N_MOS; g++) begin : g_ins
        assign gt[g] = res > list_q[g];
        if (g == 0) begin : g_head
            assign list_ins[g] = gt[g] ? res : list_q[g];
        end else begin : g_tail
            assign list_ins[g] = gt[g] ? (gt[g-1] ? list_q[g-1] : res) : list_q[g];
        end
    end

    always_comb begin
        a = mode_q[1] ? list_q[0] : list_q[N_MOS-3];
        b = mode_q[1] ? list_q[1] : list_q[N_MOS-2];
        c = mode_q[1] ? list_q[2] : list_q[N_MOS-1];
        if (mode_q[0])
            sum = SUM_W'(WT_A) * SUM_W'(a) + SUM_W'(WT_B) * SUM_W'(b) + SUM_W'(WT_C) * SUM_W'(c);
        else
            sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_n     <= '0;
            beat_cnt  <= '0;
            calc_cnt  <= '0;
            mode_q    <= '0;
            w_q       <= '0;
            vgs_q     <= '0;
            vds_q     <= '0;
            list_q    <= '0;
`ifdef SMC_PROTO_CHK_EN
            err       <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            out_n     <= '0;
`ifdef SMC_PROTO_CHK_EN
            err       <= in_valid && (state == CALC || state == AVG || state == OUT);
`endif
            case (state)
                IDLE: if (in_valid) begin
                    w_q[0]   <= W;
                    vgs_q[0] <= V_GS;
                    vds_q[0] <= V_DS;
                    mode_q   <= mode;
                    list_q   <= '0;
                    beat_cnt <= CW'(1);
                    state    <= LOAD;
                end
                LOAD: if (in_valid) begin
                    for (int i = 1; i < N_MOS; i++) begin
                        if (beat_cnt == CW'(i)) begin
                            w_q[i]   <= W;
                            vgs_q[i] <= V_GS;
                            vds_q[i] <= V_DS;
                        end
                    end
                    if (beat_cnt == CW'(N_MOS - 1)) begin
                        beat_cnt <= '0;
                        calc_cnt <= '0;
                        state    <= CALC;
                    end else begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end else begin
`ifdef SMC_PROTO_CHK_EN
                    err      <= 1'b1;
                    beat_cnt <= '0;
                    state    <= IDLE;
`endif
                end
                CALC: begin
                    list_q   <= list_ins;
                    calc_cnt <= calc_cnt + CW'(1);
                    if (calc_cnt == CW'(N_MOS - 1)) state <= AVG;
                end
                AVG: begin
                    out_n     <= OUT_W'(sum / SUM_W'(mode_q[0] ? DIV_WT : DIV_MEAN));
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
